// File: rtl/nmp_axil_master_if.sv
// -----------------------------------------------------------------------------
// nmp_axil_master_if
// Bundles the command/response handshake and the AXI4-Lite master channels of
// nmp_axil_master.
//   master modport : view of the initiator (nmp_axil_master)
//   slave  modport : view of the command source + AXI target (bench / system)
// Signals:
//   cmd_*   : single-beat command in (valid/ready)
//   rsp_*   : completion out (valid/ready) with read data, resp code, timeout
//   M_AXI_* : AXI4-Lite AW, W, B, AR and R channels
// -----------------------------------------------------------------------------
interface nmp_axil_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;

    logic [ADDR_W-1:0]     M_AXI_AWADDR;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_W-1:0]     M_AXI_WDATA;
    logic [DATA_W/8-1:0]   M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_W-1:0]     M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_W-1:0]     M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );
endinterface

// File: rtl/nmp_axil_master.sv
// -----------------------------------------------------------------------------
// nmp_axil_master
// AXI4-Lite initiator for the NMP wrapper slave port. Turns single-beat
// commands into one AXI4-Lite write or read and returns the completion.
// One transaction outstanding at a time.
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : synchronous active-high reset, overrides everything
//   bus    : nmp_axil_master_if.master (command, response, AXI channels)
// All AXI and response outputs are registered. cmd_ready is high only in IDLE.
// A bus-wait state lasting TIMEOUT cycles abandons the transaction and
// reports rsp_timeout=1 / rsp_resp=2'b10. Dropping VALID without a handshake
// is not AXI compliant: that path exists only for debug recovery.
// -----------------------------------------------------------------------------
module nmp_axil_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    nmp_axil_master_if.master     bus
);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_RESP
    } state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_awaddr, w_awaddr_next, r_araddr, w_araddr_next;
    logic [DATA_W-1:0]   r_wdata, w_wdata_next;
    logic [STRB_W-1:0]   r_wstrb, w_wstrb_next;
    logic                r_awvalid, w_awvalid_next, r_wvalid, w_wvalid_next;
    logic                r_bready, w_bready_next;
    logic                r_arvalid, w_arvalid_next, r_rready, w_rready_next;
    logic                r_aw_done, w_aw_done_next, r_w_done, w_w_done_next;
    logic                r_rsp_valid, w_rsp_valid_next;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_next;
    logic [1:0]          r_rsp_resp, w_rsp_resp_next;
    logic                r_rsp_timeout, w_rsp_timeout_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;

    logic w_cmd_ready, w_accept;
    logic w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
    logic w_aw_all, w_w_all, w_wait, w_timeout;

    assign w_cmd_ready = (r_state == S_IDLE) && !ARESET;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_aw_fire   = r_awvalid && bus.M_AXI_AWREADY;
    assign w_w_fire    = r_wvalid  && bus.M_AXI_WREADY;
    assign w_b_fire    = r_bready  && bus.M_AXI_BVALID;
    assign w_ar_fire   = r_arvalid && bus.M_AXI_ARREADY;
    assign w_r_fire    = r_rready  && bus.M_AXI_RVALID;
    // AW and W complete independently; "all" includes a handshake this cycle.
    assign w_aw_all    = r_aw_done || w_aw_fire;
    assign w_w_all     = r_w_done  || w_w_fire;
    assign w_wait      = (r_state == S_WR_AW_W) || (r_state == S_WR_B) ||
                         (r_state == S_RD_AR)   || (r_state == S_RD_R);
    // Counter holds cycles already spent here; firing on TIMEOUT-1 means the
    // VALID/READY output was high for exactly TIMEOUT cycles.
    assign w_timeout   = (TIMEOUT != 0) && w_wait && (r_cnt == CNT_W'(TO_LIM));

    // State register (plus the registered outputs it sequences)
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= S_IDLE;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_awaddr      <= w_awaddr_next;
            r_araddr      <= w_araddr_next;
            r_wdata       <= w_wdata_next;
            r_wstrb       <= w_wstrb_next;
            r_awvalid     <= w_awvalid_next;
            r_wvalid      <= w_wvalid_next;
            r_bready      <= w_bready_next;
            r_arvalid     <= w_arvalid_next;
            r_rready      <= w_rready_next;
            r_aw_done     <= w_aw_done_next;
            r_w_done      <= w_w_done_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_rdata   <= w_rsp_rdata_next;
            r_rsp_resp    <= w_rsp_resp_next;
            r_rsp_timeout <= w_rsp_timeout_next;
            r_cnt         <= w_cnt_next;
        end
    end

    // Next-state logic. A real completion always wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_next = bus.cmd_write ? S_WR_AW_W : S_RD_AR;
            S_WR_AW_W: if (w_aw_all && w_w_all) w_state_next = S_WR_B;
                       else if (w_timeout)      w_state_next = S_RESP;
            S_WR_B:    if (w_b_fire || w_timeout) w_state_next = S_RESP;
            S_RD_AR:   if (w_ar_fire)      w_state_next = S_RD_R;
                       else if (w_timeout) w_state_next = S_RESP;
            S_RD_R:    if (w_r_fire || w_timeout) w_state_next = S_RESP;
            S_RESP:    if (bus.rsp_ready)  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        logic abandon;
        abandon            = 1'b0;
        w_awaddr_next      = r_awaddr;
        w_araddr_next      = r_araddr;
        w_wdata_next       = r_wdata;
        w_wstrb_next       = r_wstrb;
        w_awvalid_next     = r_awvalid;
        w_wvalid_next      = r_wvalid;
        w_bready_next      = r_bready;
        w_arvalid_next     = r_arvalid;
        w_rready_next      = r_rready;
        w_aw_done_next     = r_aw_done;
        w_w_done_next      = r_w_done;
        w_rsp_valid_next   = r_rsp_valid;
        w_rsp_rdata_next   = r_rsp_rdata;
        w_rsp_resp_next    = r_rsp_resp;
        w_rsp_timeout_next = r_rsp_timeout;
        // Cleared on every state entry, counts while parked in a wait state
        w_cnt_next         = (w_wait && (w_state_next == r_state)) ? r_cnt + 1'b1 : '0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_write) begin
                        w_awaddr_next  = bus.cmd_addr;
                        w_wdata_next   = bus.cmd_wdata;
                        w_wstrb_next   = bus.cmd_wstrb;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                        w_aw_done_next = 1'b0;
                        w_w_done_next  = 1'b0;
                    end else begin
                        w_araddr_next  = bus.cmd_addr;
                        w_arvalid_next = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                if (w_aw_fire) begin
                    w_awvalid_next = 1'b0;
                    w_aw_done_next = 1'b1;
                end
                if (w_w_fire) begin
                    w_wvalid_next = 1'b0;
                    w_w_done_next = 1'b1;
                end
                if (w_aw_all && w_w_all) begin
                    w_bready_next = 1'b1;
                end else if (w_timeout) begin
                    w_awvalid_next = 1'b0;
                    w_wvalid_next  = 1'b0;
                    abandon        = 1'b1;
                end
            end
            S_WR_B: begin
                if (w_b_fire) begin
                    w_bready_next      = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_rdata_next   = '0;
                    w_rsp_resp_next    = bus.M_AXI_BRESP;
                    w_rsp_timeout_next = 1'b0;
                end else if (w_timeout) begin
                    w_bready_next = 1'b0;
                    abandon       = 1'b1;
                end
            end
            S_RD_AR: begin
                if (w_ar_fire) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                end else if (w_timeout) begin
                    w_arvalid_next = 1'b0;
                    abandon        = 1'b1;
                end
            end
            S_RD_R: begin
                if (w_r_fire) begin
                    w_rready_next      = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_rdata_next   = bus.M_AXI_RDATA;
                    w_rsp_resp_next    = bus.M_AXI_RRESP;
                    w_rsp_timeout_next = 1'b0;
                end else if (w_timeout) begin
                    w_rready_next = 1'b0;
                    abandon       = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) w_rsp_valid_next = 1'b0;
            end
            default: ;
        endcase

        if (abandon) begin
            w_rsp_valid_next   = 1'b1;
            w_rsp_rdata_next   = '0;
            w_rsp_resp_next    = 2'b10;
            w_rsp_timeout_next = 1'b1;
        end
    end

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_resp      = r_rsp_resp;
    assign bus.rsp_timeout   = r_rsp_timeout;
    assign bus.M_AXI_AWADDR  = r_awaddr;
    assign bus.M_AXI_AWVALID = r_awvalid;
    assign bus.M_AXI_WDATA   = r_wdata;
    assign bus.M_AXI_WSTRB   = r_wstrb;
    assign bus.M_AXI_WVALID  = r_wvalid;
    assign bus.M_AXI_BREADY  = r_bready;
    assign bus.M_AXI_ARADDR  = r_araddr;
    assign bus.M_AXI_ARVALID = r_arvalid;
    assign bus.M_AXI_RREADY  = r_rready;
endmodule
